display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Time-multiplexed scan controller for the clock's seven-segment display. The design uses one shared BCD-to-segment decoder for all digits. This block sequences that decoder across the digit positions: it presents one BCD nibble at a time, drives a one-hot digit enable, and inserts a blanking gap between digits to prevent ghosting. It sits between the timekeeping counters (packed BCD digits) and the shared decoder and digit drivers, and also implements per-digit blinking for time-set mode.

## Interface
- NUM_DIGITS, 6, number of digit positions scanned (1..8); digit 0 is the rightmost.
- DIGIT_TICKS, 1000, clk cycles each digit is lit per slot (>=1).
- BLANK_TICKS, 50, clk cycles all digits are off before each digit is lit (>=1).

- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- digits_in  in  4*NUM_DIGITS  packed BCD; digit i at [4i+3:4i].
- blink_mask  in  NUM_DIGITS  1 = digit i participates in blinking.
- blink_tick  in  1  single-cycle pulse; toggles the blink phase.
- bcd_out  out  4  nibble to the shared decoder's data input.
- digit_sel  out  NUM_DIGITS  one-hot active-high digit enable, or all zero.
- frame_start  out  1  single-cycle pulse on the first cycle of each frame.

## Operation
- FSM has two states: BLANK and SHOW. It also keeps a slot counter `tcnt` ($clog2(max(DIGIT_TICKS,BLANK_TICKS)) bits) and a digit index `idx` ($clog2(NUM_DIGITS) bits, minimum 1).
- Reset values: state=BLANK, idx=0, tcnt=0, bcd_out=0, digit_sel=0, frame_start=0, blink_phase=0, snapshot=0.
- Frame structure: each digit gets BLANK_TICKS cycles of BLANK followed by DIGIT_TICKS cycles of SHOW. Digits are scanned in order idx = 0,1,…,NUM_DIGITS-1, then the scan wraps to 0.
- BLANK:
  - digit_sel=0.
  - On the first BLANK cycle, bcd_out is loaded with snapshot[idx]. It stays stable through the following SHOW, so the decoder has settled before the digit is lit.
  - After BLANK_TICKS cycles, go to SHOW with tcnt=0.
- SHOW:
  - digit_sel[idx] is driven from the visibility rule below for all DIGIT_TICKS cycles.
  - After DIGIT_TICKS cycles, go to BLANK. idx increments, wrapping from NUM_DIGITS-1 to 0.
- Visibility rule: the digit is lit only if snapshot[idx] <= 9 AND NOT (blink_mask[idx] AND blink_phase). Otherwise digit_sel stays 0 for the whole slot, but timing is unchanged.
- Snapshot (tear-free update):
  - On the first BLANK cycle of idx 0, the whole of digits_in is captured into snapshot, and frame_start is asserted for that same cycle.
  - Changes to digits_in mid-frame are not displayed until the next frame.
- Blinking:
  - blink_phase toggles on every clk edge where blink_tick=1, independent of frame position.
  - The new phase applies from the next SHOW slot entered. The slot in progress is unaffected because the visibility decision is registered on SHOW entry.
  - blink_tick coinciding with frame_start is legal; both take effect.
- Invalid nibbles (0xA–0xF) are still driven on bcd_out, but the digit stays dark.

## Timing
- Frame length is NUM_DIGITS*(BLANK_TICKS+DIGIT_TICKS) cycles. With the defaults this is 6300 cycles.
- The first frame_start occurs one cycle after rst_n deasserts, i.e. on the first clk edge with rst_n=1.
- bcd_out changes only on the first cycle of a BLANK slot. It is never updated while digit_sel≠0.
- At most one digit_sel bit is high at any time. digit_sel is all zero for all BLANK_TICKS cycles between consecutive lit digits.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Asserting rst_n mid-SHOW clears digit_sel asynchronously in the same instant. Scanning restarts from idx 0 with a fresh snapshot.

## Test plan
- Reset: hold rst_n=0 for 5 cycles with random inputs. Required: digit_sel=0, bcd_out=0, frame_start=0 throughout; frame_start pulses on the first cycle after release.
- Scan order: NUM_DIGITS=6, DIGIT_TICKS=4, BLANK_TICKS=2, digits_in=0x9_5_4_3_2_1. Required:
  - frame_start every 36 cycles.
  - bcd_out sequence 1,2,3,4,5,9.
  - digit_sel walks 000001→100000, each lit 4 cycles with 2 dark cycles between.
- Tear-free update: change digits_in to 0x000000 at cycle 10 of a frame. Required: that frame still shows 1..9; the next frame shows all zeros.
- Invalid nibble: digit 2 = 0xB. Required: bcd_out=0xB during slot 2, digit_sel stays 0 for that slot, and other digits are unaffected with unchanged timing.
- Blink: blink_mask=6'b110000, one blink_tick pulse. Required: digits 4 and 5 are dark in every subsequent slot until a second blink_tick, while digits 0–3 stay lit throughout.
- Reset mid-operation: drop rst_n during the SHOW slot of idx 3. Required: digit_sel goes to 0 immediately; after release, idx restarts at 0 and a new frame_start pulse is seen.

Source files
------------

// File: rtl/display_scan_controller.sv
// display_scan_controller: time-multiplexed scan for the shared BCD-to-segment
// decoder. It blanks before each digit, holds bcd_out steady while a digit is
// lit, captures a tear-free snapshot once per frame, and blanks digits
// selectively for blinking.
module display_scan_controller #(
    parameter int NUM_DIGITS  = 6,
    parameter int DIGIT_TICKS = 1000,
    parameter int BLANK_TICKS = 50
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blink_tick,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_start
);

    localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        tcnt, tcnt_nx;
    logic [IDX_W-1:0]        idx, idx_nx;
    logic [4*NUM_DIGITS-1:0] snapshot, snapshot_nx;
    logic [3:0]              bcd_nx;
    logic [NUM_DIGITS-1:0]   sel_nx;
    logic                    fs_nx;
    logic                    blink_phase;

    logic                    first_blank;
    logic [3:0]              cur_nib;
    logic                    visible;
    logic [NUM_DIGITS-1:0]   sel_onehot;

    // Slot bookkeeping and the nibble/visibility decision for the current digit.
    // On the first blank cycle of digit 0 the snapshot is being loaded on this
    // same edge, so the nibble comes straight from digits_in; this also keeps
    // BLANK_TICKS=1 correct, where SHOW is entered on that same edge.
    always_comb begin
        first_blank = (state == BLANK) && (tcnt == '0);
        cur_nib     = bcd_out;
        if (first_blank) begin
            if (idx == '0) cur_nib = digits_in[3:0];
            else           cur_nib = snapshot[4*int'(idx) +: 4];
        end
        visible    = (cur_nib <= 4'd9) && !(blink_mask[idx] && blink_phase);
        sel_onehot = NUM_DIGITS'(1) << idx;
    end

    // Next-state and next-output logic for the BLANK/SHOW scan sequence.
    always_comb begin
        state_nx    = state;
        tcnt_nx     = tcnt + CNT_W'(1);
        idx_nx      = idx;
        snapshot_nx = snapshot;
        bcd_nx      = bcd_out;
        sel_nx      = digit_sel;
        fs_nx       = 1'b0;
        case (state)
            BLANK: begin
                sel_nx = '0;
                if (first_blank) begin
                    bcd_nx = cur_nib;
                    if (idx == '0) begin
                        snapshot_nx = digits_in;
                        fs_nx       = 1'b1;
                    end
                end
                if (tcnt == BLANK_LAST) begin
                    state_nx = SHOW;
                    tcnt_nx  = '0;
                    sel_nx   = visible ? sel_onehot : '0;
                end
            end
            SHOW: begin
                if (tcnt == SHOW_LAST) begin
                    state_nx = BLANK;
                    tcnt_nx  = '0;
                    sel_nx   = '0;
                    idx_nx   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                end
            end
            default: begin
                state_nx = BLANK;
                tcnt_nx  = '0;
                sel_nx   = '0;
            end
        endcase
    end

    // State, counters, snapshot and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BLANK;
            tcnt        <= '0;
            idx         <= '0;
            snapshot    <= '0;
            bcd_out     <= '0;
            digit_sel   <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            tcnt        <= tcnt_nx;
            idx         <= idx_nx;
            snapshot    <= snapshot_nx;
            bcd_out     <= bcd_nx;
            digit_sel   <= sel_nx;
            frame_start <= fs_nx;
        end
    end

    // Blink phase flips on every blink_tick, regardless of scan position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          blink_phase <= 1'b0;
        else if (blink_tick) blink_phase <= ~blink_phase;
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: directed frame-by-frame checks of the scan
// controller with NUM_DIGITS=6, DIGIT_TICKS=4, BLANK_TICKS=2 (36-cycle frames).
module tb_display_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] digits_in;
    logic [5:0]  blink_mask;
    logic        blink_tick;
    logic [3:0]  bcd_out;
    logic [5:0]  digit_sel;
    logic        frame_start;

    int nvec = 0;
    int nerr = 0;

    display_scan_controller #(
        .NUM_DIGITS (6),
        .DIGIT_TICKS(4),
        .BLANK_TICKS(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .blink_mask (blink_mask),
        .blink_tick (blink_tick),
        .bcd_out    (bcd_out),
        .digit_sel  (digit_sel),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle c of a frame is slot c/6, position c%6: positions 1..4 lit,
    // 0 and 5 dark; bcd_out holds the slot's nibble for all six cycles.
    // At cycle chg_at (after checking) new inputs are applied, with an
    // optional one-edge blink_tick pulse.
    task automatic run_frame(input int fr, input logic [23:0] exp_digs, input logic [5:0] dark,
                             input int ncyc, input int chg_at, input logic [23:0] chg_digs,
                             input logic [5:0] chg_mask, input logic chg_tick);
        for (int c = 0; c < ncyc; c++) begin
            int         s;
            int         p;
            logic [3:0] nib;
            logic [5:0] sel;
            @(negedge clk);
            s   = c / 6;
            p   = c % 6;
            nib = exp_digs[4*s +: 4];
            sel = (p >= 1 && p <= 4 && !dark[s]) ? (6'b000001 << s) : 6'b000000;
            check($sformatf("frame_start f%0d c%0d", fr, c), 32'(frame_start), 32'(c == 0));
            check($sformatf("bcd_out f%0d c%0d", fr, c), 32'(bcd_out), 32'(nib));
            check($sformatf("digit_sel f%0d c%0d", fr, c), 32'(digit_sel), 32'(sel));
            if (c == chg_at) begin
                digits_in  = chg_digs;
                blink_mask = chg_mask;
                blink_tick = chg_tick;
            end else if (c == chg_at + 1) begin
                blink_tick = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        digits_in  = '0;
        blink_mask = '0;
        blink_tick = 1'b0;

        // Reset held with random inputs: all outputs stay cleared.
        for (int i = 0; i < 5; i++) begin
            digits_in  = 24'($urandom);
            blink_mask = 6'($urandom);
            blink_tick = 1'($urandom);
            @(negedge clk);
            check($sformatf("rst digit_sel %0d", i), 32'(digit_sel), 32'h0);
            check($sformatf("rst bcd_out %0d", i), 32'(bcd_out), 32'h0);
            check($sformatf("rst frame_start %0d", i), 32'(frame_start), 32'h0);
        end
        digits_in  = 24'h954321;
        blink_mask = 6'b000000;
        blink_tick = 1'b0;
        rst_n      = 1'b1;

        // A: scan order; inputs zeroed at cycle 10 must not tear this frame.
        run_frame(0, 24'h954321, 6'b000000, 36, 10, 24'h000000, 6'b000000, 1'b0);
        // B: all zeros; load an invalid nibble in digit 2 for the next frame.
        run_frame(1, 24'h000000, 6'b000000, 36, 20, 24'h954B21, 6'b000000, 1'b0);
        // C: digit 2 dark but its nibble driven; late blink_tick leaves slot 5 lit.
        run_frame(2, 24'h954B21, 6'b000100, 36, 32, 24'h954321, 6'b110000, 1'b1);
        // D, E: digits 4 and 5 dark; second blink_tick late in E.
        run_frame(3, 24'h954321, 6'b110000, 36, -1, 24'h954321, 6'b110000, 1'b0);
        run_frame(4, 24'h954321, 6'b110000, 36, 32, 24'h954321, 6'b110000, 1'b1);
        // F: blinking back to visible.
        run_frame(5, 24'h954321, 6'b000000, 36, -1, 24'h954321, 6'b110000, 1'b0);
        // G: run into the SHOW slot of digit 3, then reset.
        run_frame(6, 24'h954321, 6'b000000, 21, -1, 24'h954321, 6'b110000, 1'b0);

        rst_n = 1'b0;
        #1;
        check("midrst digit_sel async", 32'(digit_sel), 32'h0);
        check("midrst bcd_out async", 32'(bcd_out), 32'h0);
        check("midrst frame_start async", 32'(frame_start), 32'h0);
        digits_in = 24'h123456;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("midrst hold digit_sel %0d", i), 32'(digit_sel), 32'h0);
        end
        rst_n = 1'b1;

        // H: restart from digit 0 with a fresh snapshot.
        run_frame(7, 24'h123456, 6'b000000, 36, -1, 24'h123456, 6'b110000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
